// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzifier front end: Q7.0 crisp values, Q1.15
// memberships and the packed trapezoid corner record.
package fuzzy_pkg;

  typedef logic signed [7:0] q7_t;
  typedef logic [15:0]       q15_t;

  localparam q15_t MU_ONE  = 16'h7FFF;
  localparam q15_t MU_ZERO = 16'h0000;

  typedef struct packed {
    q7_t a;
    q7_t b;
    q7_t c;
    q7_t d;
  } trap_t;

  // Which part of the trapezoid the crisp input falls on.
  typedef enum logic [1:0] {
    RGN_OUT,
    RGN_TOP,
    RGN_RISE,
    RGN_FALL
  } region_e;

endpackage

// File: rtl/fuzz_trap_mf.sv
// Combinational single-trapezoid membership evaluator.
// Classifies x against corners a,b,c,d (signed, first match wins), then
// computes the edge slope value with one shared unsigned divider whose
// operands are muxed between the rising and falling edge.
module fuzz_trap_mf
  import fuzzy_pkg::*;
#(
  parameter int FRAC_BITS = 15
) (
  input  q7_t   i_x,
  input  trap_t i_trap,
  output q15_t  o_mu
);

  // Clamp a 24-bit quotient into the Q1.15 range [0, 0x7FFF].
  function automatic q15_t sat_q15(input logic [23:0] v);
    if (v > 24'(MU_ONE)) sat_q15 = MU_ONE;
    else                 sat_q15 = v[15:0];
  endfunction

  // Floor division of (num << FRAC_BITS) by den; a zero divisor becomes 1.
  function automatic logic [23:0] div_floor(input logic [8:0] num,
                                            input logic [8:0] den);
    logic [23:0] n;
    logic [23:0] d;
    n = 24'(num) << FRAC_BITS;
    d = (den == 9'd0) ? 24'd1 : 24'(den);
    div_floor = n / d;
  endfunction

  logic signed [8:0] w_x9;
  logic signed [8:0] w_a9;
  logic signed [8:0] w_b9;
  logic signed [8:0] w_c9;
  logic signed [8:0] w_d9;

  // Sign-extend to 9 bits so differences of two Q7.0 values cannot wrap.
  assign w_x9 = {i_x[7], i_x};
  assign w_a9 = {i_trap.a[7], i_trap.a};
  assign w_b9 = {i_trap.b[7], i_trap.b};
  assign w_c9 = {i_trap.c[7], i_trap.c};
  assign w_d9 = {i_trap.d[7], i_trap.d};

  // Differences are reinterpreted as unsigned magnitudes.
  logic [8:0] w_rise_num;
  logic [8:0] w_rise_den;
  logic [8:0] w_fall_num;
  logic [8:0] w_fall_den;

  assign w_rise_num = w_x9 - w_a9;
  assign w_rise_den = w_b9 - w_a9;
  assign w_fall_num = w_d9 - w_x9;
  assign w_fall_den = w_d9 - w_c9;

  region_e w_rgn;

  // Classify x; earlier tests take priority so unordered corners still resolve.
  always_comb begin
    w_rgn = RGN_FALL;
    if (w_x9 <= w_a9 || w_x9 >= w_d9)
      w_rgn = RGN_OUT;
    else if (w_x9 >= w_b9 && w_x9 <= w_c9)
      w_rgn = RGN_TOP;
    else if (w_x9 > w_a9 && w_x9 < w_b9)
      w_rgn = RGN_RISE;
  end

  logic [8:0]  w_num;
  logic [8:0]  w_den;
  logic [23:0] w_quot;

  // Steer the active edge's operands into the single divider.
  always_comb begin
    w_num = w_fall_num;
    w_den = w_fall_den;
    if (w_rgn == RGN_RISE) begin
      w_num = w_rise_num;
      w_den = w_rise_den;
    end
  end

  assign w_quot = div_floor(w_num, w_den);

  q15_t w_mu;

  // Select the membership value for the classified region.
  always_comb begin
    w_mu = MU_ZERO;
    case (w_rgn)
      RGN_OUT:  w_mu = MU_ZERO;
      RGN_TOP:  w_mu = MU_ONE;
      RGN_RISE: w_mu = sat_q15(w_quot);
      RGN_FALL: w_mu = sat_q15(w_quot);
      default:  w_mu = MU_ZERO;
    endcase
  end

  assign o_mu = w_mu;

endmodule

// File: rtl/fuzzifier_t.sv
// Fuzzifier: one signed Q7.0 crisp input -> NEG/ZERO/POS trapezoidal
// memberships in Q1.15. Three fuzz_trap_mf evaluators feed a one-cycle
// output register stage with a matching valid bit.
// Build option FUZZIFIER_T_COMB_OUT_EN: bypass the output registers so the
// memberships and out_valid are combinational (clk/rst then unused).
module fuzzifier_t
  import fuzzy_pkg::*;
#(
  parameter int FRAC_BITS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  x,
  input  logic [7:0]  a_neg,
  input  logic [7:0]  b_neg,
  input  logic [7:0]  c_neg,
  input  logic [7:0]  d_neg,
  input  logic [7:0]  a_zero,
  input  logic [7:0]  b_zero,
  input  logic [7:0]  c_zero,
  input  logic [7:0]  d_zero,
  input  logic [7:0]  a_pos,
  input  logic [7:0]  b_pos,
  input  logic [7:0]  c_pos,
  input  logic [7:0]  d_pos,
  output logic        out_valid,
  output logic [15:0] mu_neg,
  output logic [15:0] mu_zero,
  output logic [15:0] mu_pos
);

  trap_t w_trap_neg;
  trap_t w_trap_zero;
  trap_t w_trap_pos;
  q7_t   w_x;

  assign w_x         = x;
  assign w_trap_neg  = {a_neg,  b_neg,  c_neg,  d_neg};
  assign w_trap_zero = {a_zero, b_zero, c_zero, d_zero};
  assign w_trap_pos  = {a_pos,  b_pos,  c_pos,  d_pos};

  q15_t w_mu_neg_p0;
  q15_t w_mu_zero_p0;
  q15_t w_mu_pos_p0;

  fuzz_trap_mf #(.FRAC_BITS(FRAC_BITS)) u_mf_neg (
    .i_x    (w_x),
    .i_trap (w_trap_neg),
    .o_mu   (w_mu_neg_p0)
  );

  fuzz_trap_mf #(.FRAC_BITS(FRAC_BITS)) u_mf_zero (
    .i_x    (w_x),
    .i_trap (w_trap_zero),
    .o_mu   (w_mu_zero_p0)
  );

  fuzz_trap_mf #(.FRAC_BITS(FRAC_BITS)) u_mf_pos (
    .i_x    (w_x),
    .i_trap (w_trap_pos),
    .o_mu   (w_mu_pos_p0)
  );

`ifdef FUZZIFIER_T_COMB_OUT_EN

  assign out_valid = in_valid;
  assign mu_neg    = w_mu_neg_p0;
  assign mu_zero   = w_mu_zero_p0;
  assign mu_pos    = w_mu_pos_p0;

`else

  logic r_vld_p1;
  q15_t r_mu_neg_p1;
  q15_t r_mu_zero_p1;
  q15_t r_mu_pos_p1;

  // Stage p0 -> p1: memberships load every cycle; valid follows in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_mu_neg_p1  <= MU_ZERO;
      r_mu_zero_p1 <= MU_ZERO;
      r_mu_pos_p1  <= MU_ZERO;
    end else begin
      r_vld_p1     <= in_valid;
      r_mu_neg_p1  <= w_mu_neg_p0;
      r_mu_zero_p1 <= w_mu_zero_p0;
      r_mu_pos_p1  <= w_mu_pos_p0;
    end
  end

  assign out_valid = r_vld_p1;
  assign mu_neg    = r_mu_neg_p1;
  assign mu_zero   = r_mu_zero_p1;
  assign mu_pos    = r_mu_pos_p1;

`endif

endmodule

// File: tb/tb_fuzzifier_t.sv
// Self-checking bench for fuzzifier_t: directed vector table, hand-written
// timing/reset sequences and a randomized sweep against a rule-level model.
module tb_fuzzifier_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  a_neg = 8'd0, b_neg = 8'd0, c_neg = 8'd0, d_neg = 8'd0;
  logic [7:0]  a_zero = 8'd0, b_zero = 8'd0, c_zero = 8'd0, d_zero = 8'd0;
  logic [7:0]  a_pos = 8'd0, b_pos = 8'd0, c_pos = 8'd0, d_pos = 8'd0;
  logic        out_valid;
  logic [15:0] mu_neg, mu_zero, mu_pos;

  fuzzifier_t dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .a_neg(a_neg), .b_neg(b_neg), .c_neg(c_neg), .d_neg(d_neg),
    .a_zero(a_zero), .b_zero(b_zero), .c_zero(c_zero), .d_zero(d_zero),
    .a_pos(a_pos), .b_pos(b_pos), .c_pos(c_pos), .d_pos(d_pos),
    .out_valid(out_valid), .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int c; int d; } trap_i_t;
  typedef struct {
    int xv;
    trap_i_t n, z, p;
    int en, ez, ep;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Membership straight from the rule list, using plain integers.
  function automatic int mf_ref(input int xv, input trap_i_t t);
    int num, den, q;
    if (xv <= t.a || xv >= t.d) return 0;
    if (xv >= t.b && xv <= t.c) return 32767;
    if (xv > t.a && xv < t.b) begin
      num = (xv - t.a) & 511;
      den = (t.b - t.a) & 511;
    end else begin
      num = (t.d - xv) & 511;
      den = (t.d - t.c) & 511;
    end
    if (den == 0) den = 1;
    q = ((num << 15) & 24'hFFFFFF) / den;
    return (q > 32767) ? 32767 : q;
  endfunction

  task automatic drive(input int xv, input trap_i_t n, input trap_i_t z,
                       input trap_i_t p, input logic v);
    x = 8'(xv);
    a_neg = 8'(n.a);  b_neg = 8'(n.b);  c_neg = 8'(n.c);  d_neg = 8'(n.d);
    a_zero = 8'(z.a); b_zero = 8'(z.b); c_zero = 8'(z.c); d_zero = 8'(z.d);
    a_pos = 8'(p.a);  b_pos = 8'(p.b);  c_pos = 8'(p.c);  d_pos = 8'(p.d);
    in_valid = v;
  endtask

  // Wait until the result for the currently driven inputs is visible.
  task automatic settle();
`ifdef FUZZIFIER_T_COMB_OUT_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
  endtask

  function automatic trap_i_t rand_trap();
    int q[$];
    trap_i_t t;
    for (int k = 0; k < 4; k++) q.push_back(int'($urandom_range(0, 255)) - 128);
    if ($urandom_range(0, 7) != 0) q.sort();
    t.a = q[0]; t.b = q[1]; t.c = q[2]; t.d = q[3];
    return t;
  endfunction

  // Memberships must never exceed 0x7FFF.
  always @(negedge clk) begin
    n_cmp++;
    if (mu_neg > 16'h7FFF || mu_zero > 16'h7FFF || mu_pos > 16'h7FFF) begin
      n_fail++;
      $display("FAIL mu_range: neg=%h zero=%h pos=%h, required <= 7fff",
               mu_neg, mu_zero, mu_pos);
    end
  end

  vec_t tv[13];
  trap_i_t DN, DZ, DP, P2, N2, Z2, rn, rz, rp;

  initial begin
    DN = '{-128, -64, -32, 0};
    DZ = '{-16, 0, 0, 16};
    DP = '{0, 32, 64, 127};
    P2 = '{10, 10, 20, 30};
    N2 = '{-100, -50, -20, -20};
    Z2 = '{20, -10, 30, 40};

    tv[0]  = '{-128, DN, DZ, DP, 0, 0, 0};
    tv[1]  = '{-48,  DN, DZ, DP, 32767, 0, 0};
    tv[2]  = '{-8,   DN, DZ, DP, 8192, 16384, 0};
    tv[3]  = '{0,    DN, DZ, DP, 0, 32767, 0};
    tv[4]  = '{16,   DN, DZ, DP, 0, 0, 16384};
    tv[5]  = '{127,  DN, DZ, DP, 0, 0, 0};
    tv[6]  = '{10,   DN, DZ, P2, 0, 12288, 0};
    tv[7]  = '{25,   DN, DZ, P2, 0, 0, 16384};
    tv[8]  = '{30,   DN, DZ, P2, 0, 0, 0};
    tv[9]  = '{-20,  N2, DZ, DP, 0, 0, 0};
    tv[10] = '{-21,  N2, DZ, DP, 32767, 0, 0};
    tv[11] = '{25,   DN, Z2, DP, 0, 32767, 25600};
    tv[12] = '{-100, DN, DZ, DP, 14336, 0, 0};

`ifndef FUZZIFIER_T_COMB_OUT_EN
    // Reset state, asserted away from any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_mu_neg", int'(mu_neg), 0);
    chk("rst_mu_zero", int'(mu_zero), 0);
    chk("rst_mu_pos", int'(mu_pos), 0);
    drive(-8, DN, DZ, DP, 1'b1);
    @(posedge clk); #1;
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_mu_zero", int'(mu_zero), 0);
    rst = 1'b0;
`endif

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      drive(tv[i].xv, tv[i].n, tv[i].z, tv[i].p, 1'b1);
      settle();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_mu_neg", i), int'(mu_neg), tv[i].en);
      chk($sformatf("vec%0d_mu_zero", i), int'(mu_zero), tv[i].ez);
      chk($sformatf("vec%0d_mu_pos", i), int'(mu_pos), tv[i].ep);
    end

`ifndef FUZZIFIER_T_COMB_OUT_EN
    // One-cycle latency of a single in_valid pulse.
    drive(0, DN, DZ, DP, 1'b0);
    settle();
    chk("lat_idle_valid", int'(out_valid), 0);
    chk("lat_idle_mu_zero", int'(mu_zero), 32767);
    drive(-8, DN, DZ, DP, 1'b1);
    #2;
    chk("lat_pre_valid", int'(out_valid), 0);
    chk("lat_pre_mu_zero", int'(mu_zero), 32767);
    @(posedge clk); #1;
    chk("lat_post_valid", int'(out_valid), 1);
    chk("lat_post_mu_zero", int'(mu_zero), 16384);
    drive(-8, DN, DZ, DP, 1'b0);
    settle();
    chk("lat_drop_valid", int'(out_valid), 0);
    chk("lat_drop_mu_neg", int'(mu_neg), 8192);

    // Reset mid-stream clears outputs with no clock edge.
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_mu_neg", int'(mu_neg), 0);
    chk("midrst_mu_zero", int'(mu_zero), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(-8, DN, DZ, DP, 1'b1);
    settle();
    chk("postrst_valid", int'(out_valid), 1);
    chk("postrst_mu_neg", int'(mu_neg), 8192);
`endif

    // Randomized sweep of x over random (mostly ordered) corners.
    for (int i = 0; i < 256; i++) begin
      logic v;
      int xv;
      xv = i - 128;
      rn = rand_trap();
      rz = rand_trap();
      rp = rand_trap();
      v  = 1'($urandom_range(0, 1));
      drive(xv, rn, rz, rp, v);
      settle();
      chk($sformatf("rnd%0d_valid", i), int'(out_valid), int'(v));
      chk($sformatf("rnd%0d_mu_neg x=%0d", i, xv), int'(mu_neg), mf_ref(xv, rn));
      chk($sformatf("rnd%0d_mu_zero x=%0d", i, xv), int'(mu_zero), mf_ref(xv, rz));
      chk($sformatf("rnd%0d_mu_pos x=%0d", i, xv), int'(mu_pos), mf_ref(xv, rp));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
